// File: rtl/ws2812_enc.sv
// ws2812_enc: WS2812 NRZ bit-cell encoder with a one-entry pending slot.
// Ports: clk_in, rst_n_in, bit_rdy_in, bit_data_in, bit_done_out, bit_code_out, busy_out, ovf_err_out.
module ws2812_enc #(
  parameter logic [15:0] CNT_T0H = 16'd80,
  parameter logic [15:0] CNT_T1H = 16'd160,
  parameter logic [15:0] CNT_BIT = 16'd250
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic bit_rdy_in,
  input  logic bit_data_in,
  output logic bit_done_out,
  output logic bit_code_out,
  output logic busy_out,
  output logic ovf_err_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic [15:0] cnt;
  logic [15:0] cnt_n;
  logic        cur_bit;
  logic        cur_n;
  logic        pend_vld;
  logic        pv_n;
  logic        pend_bit;
  logic        pb_n;
  logic        ovf_q;
  logic        ovf_n;
  logic        done_q;
  logic        done_n;
  logic        code_q;
  logic        busy_q;
  logic [15:0] th;
  logic        last;

  assign th   = cur_bit ? CNT_T1H : CNT_T0H;
  assign last = (state == S_LOW) &&
                (cnt == CNT_BIT - 16'd1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_n   = cur_bit;
    pv_n    = pend_vld;
    pb_n    = pend_bit;
    ovf_n   = ovf_q;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = 16'd0;
        if (bit_rdy_in) begin
          state_n = S_HIGH;
          cur_n   = bit_data_in;
        end
      end
      S_HIGH, S_LOW: begin
        cnt_n = cnt + 16'd1;
        if (state == S_HIGH &&
            cnt == th - 16'd1) begin
          state_n = S_LOW;
        end
        if (last) begin
          done_n = 1'b1;
          cnt_n  = 16'd0;
          if (pend_vld) begin
            // slot drains; a same-cycle
            // request refills it
            state_n = S_HIGH;
            cur_n   = pend_bit;
            pv_n    = bit_rdy_in;
            if (bit_rdy_in) begin
              pb_n = bit_data_in;
            end
          end else if (bit_rdy_in) begin
            state_n = S_HIGH;
            cur_n   = bit_data_in;
          end else begin
            state_n = S_IDLE;
          end
        end else if (bit_rdy_in) begin
          if (!pend_vld) begin
            pv_n = 1'b1;
            pb_n = bit_data_in;
          end else begin
            ovf_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 16'd0;
        pv_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= S_IDLE;
      cnt      <= 16'd0;
      cur_bit  <= 1'b0;
      pend_vld <= 1'b0;
      pend_bit <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur_bit  <= cur_n;
      pend_vld <= pv_n;
      pend_bit <= pb_n;
      ovf_q    <= ovf_n;
      done_q   <= done_n;
      // outputs mirror next-state so they
      // line up with the state register
      code_q   <= (state_n == S_HIGH);
      busy_q   <= (state_n != S_IDLE) | pv_n;
    end
  end

  assign bit_code_out = code_q;
  assign bit_done_out = done_q;
  assign busy_out     = busy_q;
  assign ovf_err_out  = ovf_q;

endmodule
